// File: rtl/uart_rx_frame_module_if.sv
// Serial receive bundle between the line/enable source and the UART receive engine.
// The master drives the pin and enable; the slave (receiver) returns byte, status and busy.
interface uart_rx_frame_module_if;
    logic       Rx_En_Sig;
    logic       Rx_Pin_In;
    logic [7:0] Rx_Data;
    logic       Rx_Done_Sig;
    logic       Rx_Err_Sig;
    logic       Rx_Busy;

    modport master (
        output Rx_En_Sig, Rx_Pin_In,
        input  Rx_Data, Rx_Done_Sig, Rx_Err_Sig, Rx_Busy
    );

    modport slave (
        input  Rx_En_Sig, Rx_Pin_In,
        output Rx_Data, Rx_Done_Sig, Rx_Err_Sig, Rx_Busy
    );
endinterface

// File: rtl/uart_rx_frame_module.sv
// UART receive engine: synchronises RX, times mid-bit samples from an internal baud
// divider, assembles 8 data bits LSB first with optional parity, flags framing/parity errors.
module uart_rx_frame_module #(
    parameter int BPS_DIV    = 434,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic                   CLK,
    input logic                   RST_n,
    uart_rx_frame_module_if.slave rx_if
);

    localparam int                 CNT_W     = $clog2(BPS_DIV);
    localparam logic [CNT_W-1:0]   SAMPLE_PT = CNT_W'(BPS_DIV / 2);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BPS_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic parity_err_f(input logic [7:0] data,
                                          input logic       par_bit,
                                          input logic       odd);
        return (((^data) ^ par_bit) != odd);
    endfunction

    logic             sync1_r, sync2_r, prev_r;
    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       bit_idx_r, bit_idx_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic             par_err_r, par_err_nxt_s;
    logic [7:0]       data_r, data_nxt_s;
    logic             err_r, err_nxt_s;
    logic             done_r, done_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             rx_s, fall_s, sample_s;

    assign rx_s     = sync2_r;
    assign fall_s   = prev_r & ~sync2_r;
    assign sample_s = (cnt_r == SAMPLE_PT);

    // Next-state, counter, shift register and output-register updates
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        par_err_nxt_s = par_err_r;
        data_nxt_s    = data_r;
        err_nxt_s     = err_r;
        done_nxt_s    = 1'b0;
        if (!rx_if.Rx_En_Sig) begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = '0;
            bit_idx_nxt_s = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_nxt_s = '0;
                    if (fall_s) begin
                        state_nxt_s   = ST_START;
                        par_err_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (sample_s) begin
                        // A high line at mid-start means the edge was a glitch
                        state_nxt_s   = rx_s ? ST_IDLE : ST_DATA;
                        bit_idx_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_nxt_s[bit_idx_r] = rx_s;
                        if (bit_idx_r == 3'd7) begin
                            state_nxt_s = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_nxt_s = bit_idx_r + 3'd1;
                        end
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (sample_s) begin
                        par_err_nxt_s = parity_err_f(shift_r, rx_s, PARITY_ODD);
                        state_nxt_s   = ST_STOP;
                    end else begin
                        state_nxt_s = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught
                    if (sample_s) begin
                        state_nxt_s = ST_DONE;
                        data_nxt_s  = shift_r;
                        err_nxt_s   = ~rx_s | par_err_r;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        busy_nxt_s = (state_nxt_s == ST_START) || (state_nxt_s == ST_DATA) ||
                     (state_nxt_s == ST_PARITY) || (state_nxt_s == ST_STOP);
    end

    // Synchroniser, edge detect, FSM state and registered outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            prev_r    <= 1'b1;
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            par_err_r <= 1'b0;
            data_r    <= 8'h00;
            err_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            sync1_r   <= rx_if.Rx_Pin_In;
            sync2_r   <= sync1_r;
            prev_r    <= sync2_r;
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            par_err_r <= par_err_nxt_s;
            data_r    <= data_nxt_s;
            err_r     <= err_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign rx_if.Rx_Data     = data_r;
    assign rx_if.Rx_Done_Sig = done_r;
    assign rx_if.Rx_Err_Sig  = err_r;
    assign rx_if.Rx_Busy     = busy_r;

endmodule

// File: tb/tb_uart_rx_frame_module.sv
// Directed plus randomized bench for uart_rx_frame_module: an 8N1 receiver and an even-parity
// receiver, both at 16 clocks per bit, checked against a frame-level reference model.
module tb_uart_rx_frame_module;

    localparam int BPS = 16;

    logic CLK = 1'b0;
    logic RST_n;
    logic en0, pin0, en1, pin1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [40:0] q0[$];
    logic [40:0] q1[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    uart_rx_frame_module_if if0 ();
    uart_rx_frame_module_if if1 ();

    assign if0.Rx_En_Sig = en0;
    assign if0.Rx_Pin_In = pin0;
    assign if1.Rx_En_Sig = en1;
    assign if1.Rx_Pin_In = pin1;

    uart_rx_frame_module #(.BPS_DIV(BPS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .CLK(CLK), .RST_n(RST_n), .rx_if(if0));
    uart_rx_frame_module #(.BPS_DIV(BPS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .CLK(CLK), .RST_n(RST_n), .rx_if(if1));

    // Record every Done cycle with its byte, error flag and cycle stamp
    always @(negedge CLK) begin
        if (if0.Rx_Done_Sig === 1'b1) q0.push_back({if0.Rx_Err_Sig, if0.Rx_Data, cyc});
        if (if1.Rx_Done_Sig === 1'b1) q1.push_back({if1.Rx_Err_Sig, if1.Rx_Data, cyc});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive one frame: start, D0..D7, parity (receiver 1 only), stop; returns the start cycle
    task automatic send_frame(input bit sel, input logic [7:0] b, input bit par,
                              input bit stop, output int t0);
        bit bits[$];
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (sel) bits.push_back(par);
        bits.push_back(stop);
        t0 = cyc;
        foreach (bits[i]) begin
            if (sel) pin1 = bits[i]; else pin0 = bits[i];
            idle(BPS);
        end
        if (sel) pin1 = 1'b1; else pin0 = 1'b1;
    endtask

    // Reference: Done appears 3 sync/edge clocks plus the frame latency after the start drive
    task automatic expect_done(input bit sel, input int t0, input bit pe, input logic [7:0] d,
                               input bit e, input string tag, output int got_cyc);
        logic [40:0] ev;
        int n;
        bit got;
        n = 0; got = 1'b0; ev = '0; got_cyc = -1;
        while (((sel ? q1.size() : q0.size()) == 0) && n < 400) begin
            @(posedge CLK);
            n++;
        end
        if (n > 0) #1;
        if (sel && q1.size() > 0) begin ev = q1.pop_front(); got = 1'b1; end
        else if (!sel && q0.size() > 0) begin ev = q0.pop_front(); got = 1'b1; end
        chk({tag, "_seen"}, 41'(got), 41'd1);
        if (got) begin
            got_cyc = ev[31:0];
            chk({tag, "_latency"}, 41'(ev[31:0]), 41'(t0 + 3 + (9 + pe) * BPS + BPS / 2 + 1));
            chk({tag, "_data"}, 41'(ev[39:32]), 41'(d));
            chk({tag, "_err"}, 41'(ev[40]), 41'(e));
        end
    endtask

    initial begin
        int t, t2, c1, c2, gap;
        logic [7:0] b;
        bit sel, stop, par, e;

        en0 = 1'b1; en1 = 1'b1; pin0 = 1'b1; pin1 = 1'b1; RST_n = 1'b0;
        idle(4);
        chk("reset0", 41'({if0.Rx_Busy, if0.Rx_Err_Sig, if0.Rx_Done_Sig, if0.Rx_Data}), 41'd0);
        chk("reset1", 41'({if1.Rx_Busy, if1.Rx_Err_Sig, if1.Rx_Done_Sig, if1.Rx_Data}), 41'd0);
        RST_n = 1'b1;
        idle(5);

        send_frame(1'b0, 8'h55, 1'b0, 1'b1, t);
        expect_done(1'b0, t, 1'b0, 8'h55, 1'b0, "f55", c1);
        idle(7);

        send_frame(1'b0, 8'hA3, 1'b0, 1'b1, t);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, t2);
        expect_done(1'b0, t, 1'b0, 8'hA3, 1'b0, "b2b_a3", c1);
        expect_done(1'b0, t2, 1'b0, 8'h3C, 1'b0, "b2b_3c", c2);
        chk("b2b_spacing", 41'(c2 - c1), 41'd160);
        idle(10);

        // Start glitch: four clocks low then high again
        pin0 = 1'b0;
        idle(4);
        chk("glitch_busy_hi", 41'(if0.Rx_Busy), 41'd1);
        pin0 = 1'b1;
        idle(9);
        chk("glitch_busy_lo", 41'(if0.Rx_Busy), 41'd0);
        idle(30);
        chk("glitch_no_done", 41'(q0.size()), 41'd0);
        chk("glitch_data", 41'(if0.Rx_Data), 41'h3C);

        send_frame(1'b0, 8'h81, 1'b0, 1'b0, t);
        expect_done(1'b0, t, 1'b0, 8'h81, 1'b1, "frame_err", c1);
        idle(20);
        send_frame(1'b0, 8'h7E, 1'b0, 1'b1, t);
        expect_done(1'b0, t, 1'b0, 8'h7E, 1'b0, "after_err", c1);
        idle(10);

        send_frame(1'b1, 8'h07, 1'b1, 1'b1, t);
        expect_done(1'b1, t, 1'b1, 8'h07, 1'b0, "par_ok", c1);
        idle(10);
        send_frame(1'b1, 8'h07, 1'b0, 1'b1, t);
        expect_done(1'b1, t, 1'b1, 8'h07, 1'b1, "par_bad", c1);
        idle(10);

        // Abort in the middle of D4 by dropping the enable
        fork
            send_frame(1'b0, 8'hC5, 1'b0, 1'b1, t);
            begin
                idle(88);
                en0 = 1'b0;
            end
        join
        idle(20);
        chk("abort_no_done", 41'(q0.size()), 41'd0);
        chk("abort_busy", 41'(if0.Rx_Busy), 41'd0);
        chk("abort_data", 41'({if0.Rx_Err_Sig, if0.Rx_Data}), 41'h07E);
        en0 = 1'b1;
        idle(5);
        send_frame(1'b0, 8'h12, 1'b0, 1'b1, t);
        expect_done(1'b0, t, 1'b0, 8'h12, 1'b0, "reenable", c1);
        idle(10);

        for (int i = 0; i < 10; i++) begin
            sel  = $urandom_range(0, 1);
            b    = 8'($urandom);
            par  = $urandom_range(0, 1);
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(1, 20);
            e    = !stop || (sel && ((($countones(b) + par) % 2) != 0));
            idle(gap);
            send_frame(sel, b, par, stop, t);
            expect_done(sel, t, sel, b, e, $sformatf("rand%0d", i), c1);
        end
        idle(20);

        // Enable raised while the line is already low must not start a frame
        en0 = 1'b0;
        pin0 = 1'b0;
        idle(20);
        en0 = 1'b1;
        idle(40);
        chk("en_low_line_busy", 41'(if0.Rx_Busy), 41'd0);
        pin0 = 1'b1;
        idle(20);
        chk("en_low_line_no_done", 41'(q0.size()), 41'd0);

        send_frame(1'b0, 8'h6B, 1'b0, 1'b1, t);
        expect_done(1'b0, t, 1'b0, 8'h6B, 1'b0, "pre_reset", c1);
        idle(10);

        fork
            send_frame(1'b0, 8'h99, 1'b0, 1'b1, t);
            begin
                idle(50);
                chk("rst_busy_before", 41'(if0.Rx_Busy), 41'd1);
                RST_n = 1'b0;
                #2;
                chk("rst_async0", 41'({if0.Rx_Busy, if0.Rx_Err_Sig, if0.Rx_Done_Sig, if0.Rx_Data}), 41'd0);
                chk("rst_async1", 41'({if1.Rx_Busy, if1.Rx_Err_Sig, if1.Rx_Done_Sig, if1.Rx_Data}), 41'd0);
            end
        join
        RST_n = 1'b1;
        idle(30);
        chk("rst_no_done", 41'(q0.size() + q1.size()), 41'd0);
        chk("rst_hold0", 41'({if0.Rx_Busy, if0.Rx_Err_Sig, if0.Rx_Data}), 41'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_module.md
Name: uart_rx_frame_module

Overview:
- UART receive engine; counterpart of the board's UART transmit control path.
- Synchronises the asynchronous RX pin and detects the start bit.
- Times its own mid-bit samples from an internal baud divider (no external BPS_CLK).
- Assembles 8 data bits LSB first, with optional parity; delivers a byte, a done pulse and an error flag to the downstream control logic (loopback/echo, FIFO write).

Parameters:
- BPS_DIV, 434, clocks per bit (50 MHz / 115200); legal range >= 8.
- PARITY_EN, 0, 1 = a parity bit follows D7 and is checked.
- PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 even, 1 odd).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- Rx_En_Sig  in  1  receive enable; low aborts and holds the block idle.
- Rx_Pin_In  in  1  raw serial input; idle high.
- Rx_Data  out  8  last received byte.
- Rx_Done_Sig  out  1  one-CLK pulse: frame complete.
- Rx_Err_Sig  out  1  framing/parity error for the frame flagged by Rx_Done_Sig.
- Rx_Busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (async, RST_n low):
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - Rx_Data = 8'h00; Rx_Done_Sig = 0; Rx_Err_Sig = 0; Rx_Busy = 0.
- Input path:
  - 2-flop synchroniser followed by one edge-detect flop.
  - Start is a falling edge seen on the synchronised signal.
  - All sampling uses the synchronised signal only.
- Baud counter: runs 0..BPS_DIV-1 and wraps. It is cleared on the start-edge cycle. Sample point = count reaching BPS_DIV/2 (integer divide).
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: Rx_Busy=0. On a falling edge with Rx_En_Sig=1 -> START, counter cleared.
  - START: at the sample point, a synchronised line of 0 -> DATA with bit index 0. A line of 1 -> IDLE (glitch/false start; no Done, no Err).
  - DATA: each sample point shifts the sampled bit into position [bit index] of a shift register. After bit 7 -> PARITY if PARITY_EN, else STOP.
  - PARITY: samples one bit. Parity error = (XOR of data bits ^ sampled bit) != PARITY_ODD.
  - STOP: samples one bit; a 0 is a framing error. -> DONE.
  - DONE: lasts exactly one cycle, then -> IDLE unconditionally.
- DONE-cycle outputs:
  - Rx_Done_Sig = 1.
  - Rx_Data is loaded from the shift register in the same cycle, and Rx_Err_Sig = framing OR parity error.
  - Rx_Data and Rx_Err_Sig hold until the next DONE or reset.
  - The byte is delivered even when the frame is in error.
- Latency: Rx_Done_Sig rises (9 + PARITY_EN)*BPS_DIV + BPS_DIV/2 + 1 clocks after the start-edge detect cycle.
- Back-to-back frames: FSM returns to IDLE half a bit before the nominal stop end, so a start edge arriving immediately after the stop bit is caught. There is no lost frame at full line rate.
- Rx_Busy = 1 in START, DATA, PARITY and STOP.
- Rx_En_Sig low in any state: next cycle state = IDLE and counters are cleared. Rx_Data and Rx_Err_Sig are unchanged. No Done is issued for the aborted frame.
- Rx_En_Sig rising while the line is already low: no start is taken until a new falling edge.
- Line stuck low after a framing error: no new start until the line goes high and then falls again.

Test Plan (BPS_DIV=16 unless noted):
- Send 0x55, 8N1, ideal timing -> single Rx_Done_Sig pulse at 9*16+8+1 = 153 clocks after edge detect; Rx_Data=0x55, Rx_Err_Sig=0.
- 0xA3 then 0x3C back-to-back with no idle gap -> two Done pulses exactly 160 clocks apart; Rx_Data=0xA3 then 0x3C, Err=0 both.
- Start glitch: line low for 4 clocks, then high -> no Done, Rx_Busy back to 0 within 9 clocks; previous Rx_Data unchanged.
- Framing error: 0x81 with stop bit driven low -> Done pulse, Rx_Data=0x81, Rx_Err_Sig=1. A following clean 0x7E clears Err to 0.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity bit 1 -> Err=0. The same byte with parity bit 0 -> Err=1. Done latency = 169 clocks.
- Abort and reset:
  - Rx_En_Sig dropped mid-DATA (bit 4) -> no Done; state IDLE.
  - Re-enable, send 0x12 -> correct byte.
  - RST_n asserted mid-frame -> all outputs 0 immediately.
